// File: rtl/mmu_pt_writer.sv
// rtl/mmu_pt_writer.sv - page table RAM write-side controller (map/unmap command sequencer)
module mmu_pt_writer #(
    parameter int PT_AW  = 12,
    parameter int PE_W   = 8,
    parameter int NPAGES = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [PT_AW-1:0]           cmd_ptb,
    input  logic [$clog2(NPAGES)-1:0]  cmd_vpage,
    input  logic [$clog2(NPAGES):0]    cmd_count,
    input  logic [PE_W-1:0]            cmd_entry,
    output logic                       pt_we,
    output logic [PT_AW-1:0]           pt_waddr,
    output logic [PE_W-1:0]            pt_wdata,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int VW = $clog2(NPAGES);
    localparam int CW = VW + 1;

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_FILL   = 2'b01;
    localparam logic [1:0] OP_LINEAR = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      idx_q;
    logic [CW-1:0]      n_q;
    logic               linear_q;
    logic               pt_we_q;
    logic [PT_AW-1:0]   pt_waddr_q;
    logic [PE_W-1:0]    pt_wdata_q;
    logic               ready_q;
    logic               done_q;
    logic               err_q;

    // Decoded view of the command on the inputs, used only at the accepting edge
    logic [VW-1:0]      vpage_d;
    logic [VW+1:0]      span_d;
    logic [PE_W-1:0]    lin_end_d;
    logic               bad_d;
    logic [CW-1:0]      n_d;
    logic [PE_W-1:0]    data_d;
    logic [PT_AW-1:0]   addr_d;

    // Command decode: effective page, write count, first address/data and rejection test
    always_comb begin
        vpage_d   = (cmd_op == OP_CLEAR) ? '0 : cmd_vpage;
        span_d    = (VW+2)'(vpage_d) + (VW+2)'(cmd_count);
        // Last LINEAR page number plus one; it must not pass the 7-bit page range
        lin_end_d = PE_W'(cmd_entry[PE_W-2:0]) + PE_W'(cmd_count);
        bad_d     = 1'b0;
        if (cmd_op == OP_FILL || cmd_op == OP_LINEAR) begin
            if (cmd_count == '0 || span_d > (VW+2)'(NPAGES))
                bad_d = 1'b1;
        end
        if (cmd_op == OP_LINEAR && lin_end_d > PE_W'(1 << (PE_W-1)))
            bad_d = 1'b1;
        case (cmd_op)
            OP_WRITE: n_d = CW'(1);
            OP_CLEAR: n_d = CW'(NPAGES);
            default:  n_d = cmd_count;
        endcase
        data_d = (cmd_op == OP_CLEAR) ? '0 : cmd_entry;
        addr_d = cmd_ptb + PT_AW'(vpage_d);
    end

    // Control FSM with registered outputs; the async reset kills pt_we mid-burst
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            n_q        <= '0;
            linear_q   <= 1'b0;
            pt_we_q    <= 1'b0;
            pt_waddr_q <= '0;
            pt_wdata_q <= '0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        ready_q <= 1'b0;
                        if (bad_d) begin
                            err_q   <= 1'b1;
                            state_q <= S_ERR;
                        end else begin
                            pt_we_q    <= 1'b1;
                            pt_waddr_q <= addr_d;
                            pt_wdata_q <= data_d;
                            idx_q      <= CW'(1);
                            n_q        <= n_d;
                            linear_q   <= (cmd_op == OP_LINEAR);
                            state_q    <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (idx_q == n_q) begin
                        pt_we_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        // Address wraps naturally at the table size, like the MMU adder
                        pt_waddr_q <= pt_waddr_q + PT_AW'(1);
                        if (linear_q)
                            pt_wdata_q[PE_W-2:0] <= pt_wdata_q[PE_W-2:0] + (PE_W-1)'(1);
                        idx_q <= idx_q + CW'(1);
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                S_ERR: begin
                    err_q   <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    pt_we_q <= 1'b0;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = ready_q;
    assign busy      = ~ready_q;
    assign pt_we     = pt_we_q;
    assign pt_waddr  = pt_waddr_q;
    assign pt_wdata  = pt_wdata_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mmu_pt_writer.sv
// tb/tb_mmu_pt_writer.sv - self-checking bench for mmu_pt_writer
module tb_mmu_pt_writer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [11:0] cmd_ptb;
    logic [4:0]  cmd_vpage;
    logic [5:0]  cmd_count;
    logic [7:0]  cmd_entry;
    logic        pt_we;
    logic [11:0] pt_waddr;
    logic [7:0]  pt_wdata;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;

    mmu_pt_writer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_ptb   (cmd_ptb),
        .cmd_vpage (cmd_vpage),
        .cmd_count (cmd_count),
        .cmd_entry (cmd_entry),
        .pt_we     (pt_we),
        .pt_waddr  (pt_waddr),
        .pt_wdata  (pt_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Issues one command from idle, checks every cycle against the reference model,
    // and reports what the DUT actually wrote.
    task automatic run_cmd(input logic [1:0] op, input logic [11:0] ptb, input logic [4:0] vp,
                           input logic [5:0] cnt, input logic [7:0] ent,
                           output int n_seen, output logic err_seen,
                           output logic [11:0] a_first, output logic [11:0] a_last,
                           output logic [7:0] d_last);
        int          n;
        bit          e;
        int          vpe;
        logic [11:0] ea[$];
        logic [7:0]  ed[$];
        // reference model
        vpe = (op == 2'd3) ? 0 : int'(vp);
        case (op)
            2'd0: n = 1;
            2'd3: n = 32;
            default: n = int'(cnt);
        endcase
        e = 1'b0;
        if ((op == 2'd1 || op == 2'd2) && (cnt == 0 || int'(vp) + int'(cnt) > 32)) e = 1'b1;
        if (op == 2'd2 && int'(ent[6:0]) + int'(cnt) - 1 > 127) e = 1'b1;
        for (int i = 0; i < n; i++) begin
            ea.push_back(12'((int'(ptb) + vpe + i) % 4096));
            case (op)
                2'd2:    ed.push_back({ent[7], 7'(int'(ent[6:0]) + i)});
                2'd3:    ed.push_back(8'h00);
                default: ed.push_back(ent);
            endcase
        end
        n_seen = 0; err_seen = 1'b0; a_first = '0; a_last = '0; d_last = '0;

        @(negedge clk);
        chk("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_ptb = ptb; cmd_vpage = vp; cmd_count = cnt; cmd_entry = ent;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_ptb = 12'($urandom); cmd_vpage = 5'($urandom);
        cmd_count = 6'($urandom); cmd_entry = 8'($urandom);
        if (e) begin
            err_seen = err;
            chk("err_pulse", {31'd0, err}, 32'd1);
            chk("err_no_we", {31'd0, pt_we}, 32'd0);
            chk("err_no_done", {31'd0, done}, 32'd0);
            chk("err_busy", {31'd0, busy}, 32'd1);
            @(negedge clk);
            chk("err_one_cycle", {31'd0, err}, 32'd0);
            chk("err_ready_again", {31'd0, cmd_ready}, 32'd1);
            chk("err_no_we2", {31'd0, pt_we}, 32'd0);
            chk("err_no_done2", {31'd0, done}, 32'd0);
        end else begin
            for (int j = 0; j < n; j++) begin
                chk("we_high", {31'd0, pt_we}, 32'd1);
                chk("waddr", {20'd0, pt_waddr}, {20'd0, ea[j]});
                chk("wdata", {24'd0, pt_wdata}, {24'd0, ed[j]});
                chk("no_done_during_write", {31'd0, done | err}, 32'd0);
                if (pt_we) begin
                    if (n_seen == 0) a_first = pt_waddr;
                    a_last = pt_waddr;
                    d_last = pt_wdata;
                    n_seen++;
                end
                @(negedge clk);
            end
            chk("we_low_at_done", {31'd0, pt_we}, 32'd0);
            chk("done_pulse", {31'd0, done}, 32'd1);
            chk("no_err_at_done", {31'd0, err}, 32'd0);
            chk("waddr_hold", {20'd0, pt_waddr}, {20'd0, ea[n-1]});
            chk("ready_low_at_done", {31'd0, cmd_ready}, 32'd0);
            @(negedge clk);
            chk("done_one_cycle", {31'd0, done}, 32'd0);
            chk("ready_after_done", {31'd0, cmd_ready}, 32'd1);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [11:0] ptb;
        logic [4:0]  vpage;
        logic [5:0]  count;
        logic [7:0]  entry;
        logic        exp_err;
        int          exp_n;
        logic [11:0] exp_first;
        logic [11:0] exp_last;
        logic [7:0]  exp_dlast;
    } vec_t;

    vec_t        vecs[11];
    int          ns;
    logic        es;
    logic [11:0] af, al;
    logic [7:0]  dl;

    initial begin
        vecs[0]  = '{2'd0, 12'h040, 5'd3,  6'd0,  8'h85, 1'b0, 1,  12'h043, 12'h043, 8'h85};
        vecs[1]  = '{2'd2, 12'h100, 5'd4,  6'd3,  8'h90, 1'b0, 3,  12'h104, 12'h106, 8'h92};
        vecs[2]  = '{2'd3, 12'hFF0, 5'd7,  6'd5,  8'h55, 1'b0, 32, 12'hFF0, 12'h00F, 8'h00};
        vecs[3]  = '{2'd1, 12'h000, 5'd30, 6'd3,  8'h81, 1'b1, 0,  12'h000, 12'h000, 8'h00};
        vecs[4]  = '{2'd2, 12'h000, 5'd0,  6'd3,  8'hFE, 1'b1, 0,  12'h000, 12'h000, 8'h00};
        vecs[5]  = '{2'd2, 12'h200, 5'd0,  6'd3,  8'hFD, 1'b0, 3,  12'h200, 12'h202, 8'hFF};
        vecs[6]  = '{2'd1, 12'hFFE, 5'd29, 6'd3,  8'h81, 1'b0, 3,  12'h01B, 12'h01D, 8'h81};
        vecs[7]  = '{2'd1, 12'h010, 5'd2,  6'd0,  8'h81, 1'b1, 0,  12'h000, 12'h000, 8'h00};
        vecs[8]  = '{2'd0, 12'hFFF, 5'd31, 6'd0,  8'h7F, 1'b0, 1,  12'h01E, 12'h01E, 8'h7F};
        vecs[9]  = '{2'd2, 12'h300, 5'd0,  6'd32, 8'h80, 1'b0, 32, 12'h300, 12'h31F, 8'h9F};
        vecs[10] = '{2'd2, 12'h300, 5'd1,  6'd32, 8'h80, 1'b1, 0,  12'h000, 12'h000, 8'h00};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_ptb = '0; cmd_vpage = '0;
        cmd_count = '0; cmd_entry = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_we", {31'd0, pt_we}, 32'd0);
        chk("rst_waddr", {20'd0, pt_waddr}, 32'd0);
        chk("rst_wdata", {24'd0, pt_wdata}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done_err", {30'd0, done, err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // directed table
        for (int k = 0; k < 11; k++) begin
            run_cmd(vecs[k].op, vecs[k].ptb, vecs[k].vpage, vecs[k].count, vecs[k].entry, ns, es, af, al, dl);
            chk($sformatf("vec%0d_err", k), {31'd0, es}, {31'd0, vecs[k].exp_err});
            chk($sformatf("vec%0d_nwrites", k), ns, vecs[k].exp_n);
            if (!vecs[k].exp_err) begin
                chk($sformatf("vec%0d_first_addr", k), {20'd0, af}, {20'd0, vecs[k].exp_first});
                chk($sformatf("vec%0d_last_addr", k), {20'd0, al}, {20'd0, vecs[k].exp_last});
                chk($sformatf("vec%0d_last_data", k), {24'd0, dl}, {24'd0, vecs[k].exp_dlast});
            end
        end

        // reset during the fifth write of a CLEAR
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd3; cmd_ptb = 12'h500; cmd_vpage = 5'd9;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst_we_before", {31'd0, pt_we}, 32'd1);
        chk("midrst_addr_before", {20'd0, pt_waddr}, 32'h504);
        rst_n = 1'b0;
        #1;
        chk("midrst_we_async", {31'd0, pt_we}, 32'd0);
        chk("midrst_ready_async", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("postrst_quiet", {29'd0, pt_we, done, err}, 32'd0);
            chk("postrst_ready", {31'd0, cmd_ready}, 32'd1);
        end

        // back-to-back WRITEs with cmd_valid held high
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_ptb = 12'h020; cmd_vpage = 5'd1; cmd_entry = 8'hC3;
        for (int c = 0; c < 12; c++) begin
            chk($sformatf("b2b_ready_c%0d", c), {31'd0, cmd_ready}, {31'd0, (c % 3 == 0)});
            chk($sformatf("b2b_we_c%0d", c), {31'd0, pt_we}, {31'd0, (c % 3 == 1)});
            chk($sformatf("b2b_done_c%0d", c), {31'd0, done}, {31'd0, (c % 3 == 2)});
            if (c % 3 == 1) chk("b2b_addr", {20'd0, pt_waddr}, 32'h021);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        @(negedge clk);

        // randomized commands against the reference model
        for (int r = 0; r < 40; r++) begin
            run_cmd(2'($urandom), 12'($urandom), 5'($urandom), 6'($urandom_range(0, 33)),
                    8'($urandom), ns, es, af, al, dl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
